// File: rtl/pulse_channel_pkg.sv
// Shared encodings for the pulse-wave voice.
// Duty selects, FSM states and the duty-window compare.
package pulse_channel_pkg;

    localparam logic [1:0] DUTY_12 = 2'd0;
    localparam logic [1:0] DUTY_25 = 2'd1;
    localparam logic [1:0] DUTY_50 = 2'd2;
    localparam logic [1:0] DUTY_75 = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_t;

    function automatic logic duty_high(
        input logic [1:0] duty,
        input logic [2:0] top
    );
        logic hi;
        hi = 1'b0;
        unique case (1'b1)
            (duty == DUTY_12): hi = (top == 3'b111);
            (duty == DUTY_25): hi = (top[2:1] == 2'b11);
            (duty == DUTY_50): hi = top[2];
            default:           hi = (top[2:1] != 2'b00);
        endcase
        return hi;
    endfunction

endpackage

// File: rtl/pulse_channel_envelope.sv
// Envelope level, decay divider and note-length counter.
// A load always wins over a tick in the same cycle.
module pulse_envelope
    import pulse_channel_pkg::*;
#(
    parameter int OUT_WIDTH    = 9,
    parameter int LENGTH_WIDTH = 8,
    parameter int DECAY_WIDTH  = 4
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_load,
    input  logic                    i_tick,
    input  logic [OUT_WIDTH-1:0]    i_volume,
    input  logic [DECAY_WIDTH-1:0]  i_decay,
    input  logic [LENGTH_WIDTH-1:0] i_length,
    output logic [OUT_WIDTH-1:0]    o_level,
    output logic                    o_expire
);

    logic [OUT_WIDTH-1:0]    level_q, level_d;
    logic [DECAY_WIDTH-1:0]  decay_q, decay_d;
    logic [DECAY_WIDTH-1:0]  cnt_q, cnt_d;
    logic [LENGTH_WIDTH-1:0] len_q, len_d;

    assign o_level  = level_q;
    assign o_expire = i_tick && (len_q == LENGTH_WIDTH'(1));

    always_comb begin
        level_d = level_q;
        decay_d = decay_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        if (i_load) begin
            level_d = i_volume;
            decay_d = i_decay;
            len_d   = i_length;
            cnt_d   = '0;
        end else if (i_tick) begin
            if (decay_q != '0) begin
                if (cnt_q == decay_q - DECAY_WIDTH'(1)) begin
                    cnt_d = '0;
                    if (level_q != '0)
                        level_d = level_q - OUT_WIDTH'(1);
                end else begin
                    cnt_d = cnt_q + DECAY_WIDTH'(1);
                end
            end
            if (len_q != '0)
                len_d = len_q - LENGTH_WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            level_q <= '0;
            decay_q <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            level_q <= level_d;
            decay_q <= decay_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

endmodule

// File: rtl/pulse_channel.sv
// Pulse-wave voice: FSM, phase accumulator, pending note buffer.
// Pending notes take effect on a phase wrap or at length expiry.
module pulse_channel
    import pulse_channel_pkg::*;
#(
    parameter int PHASE_WIDTH  = 32,
    parameter int OUT_WIDTH    = 9,
    parameter int LENGTH_WIDTH = 8,
    parameter int DECAY_WIDTH  = 4
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_tick_stb,
    input  logic                    i_note_valid,
    output logic                    o_note_ready,
    input  logic [PHASE_WIDTH-1:0]  i_phase_delta,
    input  logic [1:0]              i_duty,
    input  logic [OUT_WIDTH-1:0]    i_volume,
    input  logic [DECAY_WIDTH-1:0]  i_decay,
    input  logic [LENGTH_WIDTH-1:0] i_length,
    output logic [OUT_WIDTH-1:0]    o_output,
    output logic                    o_frame_pulse,
    output logic                    o_active
);

    state_t                  state_q, state_d;
    logic [PHASE_WIDTH-1:0]  phase_q, phase_d;
    logic [PHASE_WIDTH-1:0]  delta_q, delta_d;
    logic [1:0]              duty_q, duty_d;
    logic [OUT_WIDTH-1:0]    out_q, out_d;

    logic                    pv_q, pv_d;
    logic [PHASE_WIDTH-1:0]  p_delta_q, p_delta_d;
    logic [1:0]              p_duty_q, p_duty_d;
    logic [OUT_WIDTH-1:0]    p_vol_q, p_vol_d;
    logic [DECAY_WIDTH-1:0]  p_decay_q, p_decay_d;
    logic [LENGTH_WIDTH-1:0] p_len_q, p_len_d;

    logic [PHASE_WIDTH:0]    sum;
    logic                    wrap, play, xfer, take_pend;
    logic                    env_load, env_tick, expire;
    logic [OUT_WIDTH-1:0]    env_vol, level;
    logic [DECAY_WIDTH-1:0]  env_decay;
    logic [LENGTH_WIDTH-1:0] env_len;

    assign o_note_ready  = !pv_q && !i_reset;
    assign o_output      = out_q;
    assign o_active      = (state_q == ST_PLAY);
    assign o_frame_pulse = phase_q[PHASE_WIDTH-1];

    assign sum       = {1'b0, phase_q} + {1'b0, delta_q};
    assign wrap      = sum[PHASE_WIDTH];
    assign play      = (state_q == ST_PLAY);
    assign xfer      = i_note_valid && o_note_ready;
    assign take_pend = play && pv_q && (wrap || expire);
    assign env_load  = (!play && xfer) || take_pend;
    assign env_tick  = play && i_tick_stb;
    assign env_vol   = play ? p_vol_q : i_volume;
    assign env_decay = play ? p_decay_q : i_decay;
    assign env_len   = play ? p_len_q : i_length;

    pulse_envelope #(
        .OUT_WIDTH    (OUT_WIDTH),
        .LENGTH_WIDTH (LENGTH_WIDTH),
        .DECAY_WIDTH  (DECAY_WIDTH)
    ) u_env (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_load   (env_load),
        .i_tick   (env_tick),
        .i_volume (env_vol),
        .i_decay  (env_decay),
        .i_length (env_len),
        .o_level  (level),
        .o_expire (expire)
    );

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        delta_d   = delta_q;
        duty_d    = duty_q;
        pv_d      = pv_q;
        p_delta_d = p_delta_q;
        p_duty_d  = p_duty_q;
        p_vol_d   = p_vol_q;
        p_decay_d = p_decay_q;
        p_len_d   = p_len_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    delta_d = i_phase_delta;
                    duty_d  = i_duty;
                    phase_d = '0;
                    state_d = ST_PLAY;
                end
            end
            default: begin
                phase_d = sum[PHASE_WIDTH-1:0];
                if (xfer) begin
                    pv_d      = 1'b1;
                    p_delta_d = i_phase_delta;
                    p_duty_d  = i_duty;
                    p_vol_d   = i_volume;
                    p_decay_d = i_decay;
                    p_len_d   = i_length;
                end
                // xfer and take_pend are exclusive: ready needs an empty buffer
                if (take_pend) begin
                    delta_d = p_delta_q;
                    duty_d  = p_duty_q;
                    pv_d    = 1'b0;
                    if (expire)
                        phase_d = '0;
                end else if (expire) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
        out_d = (play && duty_high(duty_q, phase_q[PHASE_WIDTH-1 -: 3]))
              ? level : '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            phase_q   <= '0;
            delta_q   <= '0;
            duty_q    <= '0;
            out_q     <= '0;
            pv_q      <= 1'b0;
            p_delta_q <= '0;
            p_duty_q  <= '0;
            p_vol_q   <= '0;
            p_decay_q <= '0;
            p_len_q   <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            delta_q   <= delta_d;
            duty_q    <= duty_d;
            out_q     <= out_d;
            pv_q      <= pv_d;
            p_delta_q <= p_delta_d;
            p_duty_q  <= p_duty_d;
            p_vol_q   <= p_vol_d;
            p_decay_q <= p_decay_d;
            p_len_q   <= p_len_d;
        end
    end

endmodule

// File: tb/tb_pulse_channel.sv
// Directed bench for pulse_channel with hand-computed expectations.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_pulse_channel;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic        valid = 1'b0;
    logic        ready;
    logic [31:0] delta = '0;
    logic [1:0]  duty = '0;
    logic [8:0]  vol = '0;
    logic [3:0]  dec = '0;
    logic [7:0]  len = '0;
    logic [8:0]  out;
    logic        frame;
    logic        active;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pulse_channel dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_tick_stb    (tick),
        .i_note_valid  (valid),
        .o_note_ready  (ready),
        .i_phase_delta (delta),
        .i_duty        (duty),
        .i_volume      (vol),
        .i_decay       (dec),
        .i_length      (len),
        .o_output      (out),
        .o_frame_pulse (frame),
        .o_active      (active)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        valid = 1'b0;
        tick = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_note(input logic [31:0] d, input logic [1:0] du,
                            input logic [8:0] v, input logic [3:0] dc,
                            input logic [7:0] ln);
        valid = 1'b1;
        delta = d;
        duty = du;
        vol = v;
        dec = dc;
        len = ln;
    endtask

    task automatic send(input logic [31:0] d, input logic [1:0] du,
                        input logic [8:0] v, input logic [3:0] dc,
                        input logic [7:0] ln);
        set_note(d, du, v, dc, ln);
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic duty_run(input logic [1:0] du, input int exp_hi,
                            input int exp_first);
        int hi, fr, first;
        do_reset();
        send(32'h1000_0000, du, 9'h1FF, 4'd0, 8'd0);
        chk($sformatf("d%0d_active", du), active, 1);
        hi = 0;
        fr = 0;
        first = -1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (out == 9'h1FF) begin
                hi++;
                if (first < 0) first = i;
            end
            if (frame) fr++;
        end
        chk($sformatf("d%0d_high", du), hi, exp_hi);
        chk($sformatf("d%0d_first", du), first, exp_first);
        chk($sformatf("d%0d_frame", du), fr, 8);
    endtask

    logic [8:0] p_out [19] = '{9'h0, 9'h0, 9'h0, 9'h0, 9'h1FF, 9'h1FF,
        9'h1FF, 9'h0, 9'h0, 9'h0, 9'h0AA, 9'h0AA, 9'h0AA, 9'h0AA,
        9'h0, 9'h0, 9'h0, 9'h0, 9'h055};
    bit p_frm [19] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 0, 0,
        0, 0, 1, 1};
    bit p_rdy [19] = '{1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1,
        1, 1, 1, 1};
    int lv_exp [6] = '{5, 5, 4, 4, 3, 3};

    initial begin
        int mx, rlow, alow, nz;

        @(negedge clk);
        chk("rst_out", out, 0);
        chk("rst_active", active, 0);
        chk("rst_ready", ready, 0);
        chk("rst_frame", frame, 0);
        rst = 1'b0;
        #1;
        chk("rst_ready_after", ready, 1);

        duty_run(2'd1, 4, 12);
        duty_run(2'd0, 2, 14);
        duty_run(2'd2, 8, 8);
        duty_run(2'd3, 12, 4);

        do_reset();
        send(32'h1000_0000, 2'd3, 9'd5, 4'd2, 8'd6);
        rlow = 0;
        alow = 0;
        for (int t = 0; t < 6; t++) begin
            mx = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (i > 0 && int'(out) > mx) mx = int'(out);
                if (!ready) rlow++;
                if (!active) alow++;
            end
            chk($sformatf("env_lvl%0d", t), mx, lv_exp[t]);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
        chk("env_ready_low", rlow, 0);
        chk("env_active_low", alow, 0);
        chk("len_expired", active, 0);
        nz = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out != 0 || active) nz++;
        end
        chk("len_idle_out", nz, 0);
        chk("len_ready", ready, 1);

        do_reset();
        send(32'h3000_0000, 2'd2, 9'h1FF, 4'd0, 8'd0);
        for (int k = 0; k < 19; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("pend_frame%0d", k), frame, p_frm[k]);
            chk($sformatf("pend_ready%0d", k), ready, p_rdy[k]);
            chk($sformatf("pend_out%0d", k), out, p_out[k]);
            if (k == 1) set_note(32'h2000_0000, 2'd2, 9'h0AA, 4'd0, 8'd0);
            if (k == 2) set_note(32'h2000_0000, 2'd2, 9'h055, 4'd0, 8'd0);
            if (k == 7) valid = 1'b0;
        end

        do_reset();
        send(32'h1000_0000, 2'd2, 9'h1FF, 4'd0, 8'd1);
        for (int k = 1; k < 20; k++) begin
            @(negedge clk);
            if (k == 1) set_note(32'h1000_0000, 2'd2, 9'h033, 4'd0, 8'd0);
            if (k == 2) begin
                valid = 1'b0;
                chk("exp_pend_ready", ready, 0);
            end
            if (k == 9) tick = 1'b1;
            if (k == 10) begin
                tick = 1'b0;
                chk("exp_active", active, 1);
                chk("exp_phase0", frame, 0);
                chk("exp_ready", ready, 1);
                chk("exp_old_out", out, 9'h1FF);
            end
            if (k == 11) chk("exp_out_gap", out, 0);
            if (k == 18) chk("exp_frame_hi", frame, 1);
            if (k == 19) begin
                chk("exp_new_vol", out, 9'h033);
                chk("exp_still_on", active, 1);
            end
        end

        do_reset();
        send(32'h1000_0000, 2'd3, 9'h1FF, 4'd0, 8'd0);
        repeat (3) @(negedge clk);
        set_note(32'h2000_0000, 2'd3, 9'h077, 4'd0, 8'd0);
        @(negedge clk);
        valid = 1'b0;
        chk("mid_pend_ready", ready, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", ready, 0);
        @(negedge clk);
        chk("mid_out", out, 0);
        chk("mid_active", active, 0);
        chk("mid_ready", ready, 0);
        chk("mid_frame", frame, 0);
        rst = 1'b0;
        #1;
        chk("mid_ready_after", ready, 1);
        nz = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out != 0 || active) nz++;
        end
        chk("mid_no_pending", nz, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
